// File: rtl/io_debounce_port_if.sv
// Board-side I/O bundle: raw switches and CPU output writes in; debounced
// switches, change pulses, output register and LED copy out.
interface io_debounce_port_if #(
    parameter int unsigned NBITS    = 8,
    parameter int unsigned NIO_BITS = 5
);
    logic [NIO_BITS-1:0] swi_raw;
    logic                saida_we;
    logic [NBITS-1:0]    saida_d;
    logic [NBITS-1:0]    entrada;
    logic                sw_changed;
    logic [NIO_BITS-1:0] sw_rise;
    logic [NBITS-1:0]    saida;
    logic [NIO_BITS-1:0] led;

    modport master (
        output swi_raw, saida_we, saida_d,
        input  entrada, sw_changed, sw_rise, saida, led
    );

    modport slave (
        input  swi_raw, saida_we, saida_d,
        output entrada, sw_changed, sw_rise, saida, led
    );
endinterface

// File: rtl/io_debounce_port.sv
// Switch synchronizer + per-bit debounce feeding the CPU input bus, and the
// CPU-written output register driving saida/LEDs.
module io_debounce_port #(
    parameter int unsigned NBITS           = 8,
    parameter int unsigned NIO_BITS        = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    io_debounce_port_if.slave  bus
);
    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NIO_BITS-1:0] s1;
    logic [NIO_BITS-1:0] s2;
    logic [NIO_BITS-1:0] stable;
    logic [NIO_BITS-1:0] stable_nxt;
    logic [NIO_BITS-1:0] upd;
    logic [CW-1:0]       cnt     [NIO_BITS];
    logic [CW-1:0]       cnt_nxt [NIO_BITS];
    logic                sw_changed;
    logic [NIO_BITS-1:0] sw_rise;
    logic [NBITS-1:0]    saida;

    // Per-bit debounce: any cycle of agreement restarts the mismatch count.
    always_comb begin
        stable_nxt = stable;
        upd        = '0;
        for (int i = 0; i < int'(NIO_BITS); i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = s2[i];
                    upd[i]        = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            stable     <= '0;
            sw_changed <= 1'b0;
            sw_rise    <= '0;
            saida      <= '0;
            for (int i = 0; i < int'(NIO_BITS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= bus.swi_raw;
            s2         <= s1;
            stable     <= stable_nxt;
            sw_changed <= |upd;
            sw_rise    <= upd & s2;
            if (bus.saida_we) begin
                saida <= bus.saida_d;
            end
            for (int i = 0; i < int'(NIO_BITS); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign bus.entrada    = NBITS'(stable);
    assign bus.sw_changed = sw_changed;
    assign bus.sw_rise    = sw_rise;
    assign bus.saida      = saida;
    assign bus.led        = saida[NIO_BITS-1:0];
endmodule

// File: tb/tb_io_debounce_port.sv
// Randomized scoreboard bench for io_debounce_port against a sliding-window
// debounce reference model.
module tb_io_debounce_port;
    localparam int unsigned NBITS = 8;
    localparam int unsigned NIO   = 5;
    localparam int unsigned DEB   = 4;

    typedef struct {
        logic [NBITS-1:0] entrada;
        logic             changed;
        logic [NIO-1:0]   rise;
        logic [NBITS-1:0] saida;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    io_debounce_port_if #(.NBITS(NBITS), .NIO_BITS(NIO)) bus();

    io_debounce_port #(
        .NBITS(NBITS), .NIO_BITS(NIO), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: a bit flips once the last DEB synchronized samples all disagree with it.
    initial begin
        logic [NIO-1:0] raw_hist[$];
        logic [NIO-1:0] sync_hist[$];
        logic [NIO-1:0] m_stable;
        logic [NIO-1:0] old;
        logic [NIO-1:0] cmp;
        logic [NBITS-1:0] m_saida;
        logic all_diff;
        exp_t e;
        m_stable = '0;
        m_saida  = '0;
        forever begin
            @(posedge clock);
            e.changed = 1'b0;
            e.rise    = '0;
            if (reset) begin
                raw_hist.delete();
                sync_hist.delete();
                raw_hist.push_back('0);
                raw_hist.push_back('0);
                m_stable = '0;
                m_saida  = '0;
            end else begin
                cmp = (raw_hist.size() > 1) ? raw_hist[1] : '0;
                raw_hist.push_front(bus.swi_raw);
                if (raw_hist.size() > 2) void'(raw_hist.pop_back());
                sync_hist.push_front(cmp);
                if (sync_hist.size() > DEB) void'(sync_hist.pop_back());
                old = m_stable;
                for (int i = 0; i < int'(NIO); i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < int'(DEB); j++) begin
                        if (j >= sync_hist.size()) all_diff = 1'b0;
                        else if (sync_hist[j][i] == m_stable[i]) all_diff = 1'b0;
                    end
                    if (all_diff) m_stable[i] = ~m_stable[i];
                end
                e.changed = |(old ^ m_stable);
                e.rise    = m_stable & ~old;
                if (bus.saida_we) m_saida = bus.saida_d;
            end
            e.entrada = NBITS'(m_stable);
            e.saida   = m_saida;
            sb.push_back(e);
        end
    end

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("entrada",    32'(bus.entrada),    32'(e.entrada));
                check("sw_changed", 32'(bus.sw_changed), 32'(e.changed));
                check("sw_rise",    32'(bus.sw_rise),    32'(e.rise));
                check("saida",      32'(bus.saida),      32'(e.saida));
                check("led",        32'(bus.led),        32'(e.saida[NIO-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic set_in(input logic r, input logic [NIO-1:0] sw,
                          input logic we, input logic [NBITS-1:0] d);
        reset        = r;
        bus.swi_raw  = sw;
        bus.saida_we = we;
        bus.saida_d  = d;
    endtask

    task automatic drive(input logic r, input logic [NIO-1:0] sw,
                         input logic we, input logic [NBITS-1:0] d, input int n);
        set_in(r, sw, we, d);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // Counts edges until entrada reaches target; 0 means it never did.
    task automatic measure(input logic [NBITS-1:0] target, output int edges);
        bit found;
        found = 1'b0;
        edges = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clock);
            #1;
            if (bus.entrada == target) begin
                found = 1'b1;
                edges = i;
            end
            #1;
        end
    endtask

    initial begin
        int n;
        logic [NIO-1:0] cur;
        logic r;
        set_in(1'b1, 5'b11111, 1'b1, 8'hFF);
        repeat (2) begin
            @(posedge clock);
            #2;
        end
        set_in(1'b0, 5'b11111, 1'b0, 8'h00);
        measure(8'h1F, n);
        check("lat_reset", 32'(n), 32'd6);
        drive(1'b0, 5'b00000, 1'b0, 8'h00, 8);

        set_in(1'b0, 5'b00100, 1'b0, 8'h00);
        measure(8'h04, n);
        check("lat_press", 32'(n), 32'd6);
        drive(1'b0, 5'b00100, 1'b0, 8'h00, 4);

        set_in(1'b0, 5'b00000, 1'b0, 8'h00);
        measure(8'h00, n);
        check("lat_release", 32'(n), 32'd6);
        drive(1'b0, 5'b00000, 1'b0, 8'h00, 3);

        drive(1'b0, 5'b00001, 1'b0, 8'h00, 3);
        drive(1'b0, 5'b00000, 1'b0, 8'h00, 1);
        drive(1'b0, 5'b00001, 1'b0, 8'h00, 3);
        drive(1'b0, 5'b00000, 1'b0, 8'h00, 8);

        set_in(1'b0, 5'b10011, 1'b0, 8'h00);
        measure(8'h13, n);
        check("lat_multi", 32'(n), 32'd6);
        drive(1'b0, 5'b10011, 1'b0, 8'h00, 4);
        drive(1'b0, 5'b00000, 1'b0, 8'h00, 8);

        drive(1'b0, 5'b00000, 1'b1, 8'hA5, 1);
        drive(1'b0, 5'b00000, 1'b1, 8'h3C, 1);
        drive(1'b0, 5'b00000, 1'b0, 8'h00, 3);
        drive(1'b1, 5'b00000, 1'b1, 8'h77, 1);
        drive(1'b0, 5'b00000, 1'b0, 8'h00, 2);

        cur = '0;
        for (int s = 0; s < 250; s++) begin
            r   = ($urandom_range(0, 39) == 0);
            cur = ($urandom_range(0, 1) == 1) ? (cur ^ NIO'($urandom)) : NIO'($urandom);
            drive(r, cur, ($urandom_range(0, 2) == 0), NBITS'($urandom),
                  int'($urandom_range(1, 7)));
        end
        drive(1'b0, cur, 1'b0, 8'h00, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
